vending_ctrl: RTL and testbench
===============================

VENDING_CTRL -- requirements
Module: vending_ctrl

Interface
REQ-001 Parameter PRICE, default 4, meaning product price in 50-won units (1..MAX_CREDIT).
REQ-002 Parameter MAX_CREDIT, default 40, meaning the highest credit in units that may be held.
REQ-003 Parameter CREDIT_W, default 8, meaning the width of the credit and change buses; 2^CREDIT_W > MAX_CREDIT+10 SHALL hold.
REQ-004 Port clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port coin_valid  input  1  a coin is presented this cycle.
REQ-007 Port coin_code  input  2  coin type: 00=50 won (1 unit), 01=100 won (2 units), 10=500 won (10 units), 11=invalid.
REQ-008 Port cancel  input  1  request refund of the current credit.
REQ-009 Port change_ack  input  1  the change dispenser has taken change_amount.
REQ-010 Port coffee_out  output  1  registered one-cycle dispense pulse.
REQ-011 Port coin_reject  output  1  registered one-cycle pulse; the sampled coin was returned and not credited.
REQ-012 Port change_valid  output  1  registered; change_amount is valid and awaiting ack.
REQ-013 Port change_amount  output  CREDIT_W  change in units; registered and stable while change_valid=1.
REQ-014 Port credit  output  CREDIT_W  current accumulated credit in units.
REQ-015 Port busy  output  1  high in the DISPENSE and CHANGE states.

Function
REQ-016 The FSM SHALL have four states: IDLE (credit=0), COLLECT (0<credit<PRICE), DISPENSE, and CHANGE.
REQ-017 A coin is accepted in IDLE or COLLECT when coin_valid=1, the code is not 11, cancel=0, and credit+value<=MAX_CREDIT; credit SHALL add the value at that edge.
REQ-018 Any coin not accepted, including one arriving in DISPENSE or CHANGE, SHALL set coin_reject high for the next cycle only, with credit unchanged.
REQ-019 If an accepted coin makes credit+value>=PRICE, the FSM SHALL enter DISPENSE at that same edge, and coffee_out SHALL be high for exactly the following cycle.
REQ-020 If an accepted coin leaves the sum below PRICE, the FSM SHALL enter COLLECT.
REQ-021 DISPENSE SHALL last one cycle; on exit, credit SHALL become credit-PRICE.
REQ-022 If the remainder after DISPENSE is greater than 0, the FSM SHALL enter CHANGE with change_valid=1 and change_amount=remainder.
REQ-023 If the remainder after DISPENSE is 0, the FSM SHALL enter IDLE.
REQ-024 cancel in COLLECT SHALL enter CHANGE with change_amount=credit.
REQ-025 cancel in IDLE, DISPENSE, or CHANGE SHALL be ignored.
REQ-026 cancel and coin_valid asserted together SHALL act as cancel, and the coin SHALL be rejected.
REQ-027 In CHANGE, outputs SHALL hold until change_ack is sampled high; at that edge, change_valid=0, credit=0, and the FSM SHALL enter IDLE.
REQ-028 change_ack outside CHANGE SHALL be ignored.
REQ-029 Credit SHALL never exceed MAX_CREDIT and SHALL never wrap.
REQ-030 Only one product SHALL be dispensed per visit to DISPENSE; there is no back-to-back dispense from residual credit.

Reset
REQ-031 While reset=1, the FSM SHALL be forced to IDLE immediately and asynchronously, including mid-DISPENSE or mid-CHANGE.
REQ-032 While reset=1, all outputs SHALL be 0: coffee_out, coin_reject, change_valid, change_amount, credit, busy.
REQ-033 Credit held when reset is asserted SHALL be discarded, with no change issued.
REQ-034 Operation SHALL resume on the first rising clk edge after reset deasserts.

Structure
REQ-035 Package vending_pkg SHALL hold the state encoding, the coin-code constants, and the unit values 1/2/10.
REQ-036 Sub-module vending_coin_decode (combinational) SHALL map coin_code to a value in units and an is_valid flag.
REQ-037 All other logic SHALL reside in vending_ctrl.

Verification
REQ-038 Two coins, code 01 then 01, PRICE=4 -> credit goes 2 then 4, coffee_out pulses once, no change, ends in IDLE.
REQ-039 One coin, code 10, PRICE=4 -> coffee_out pulse, then change_valid=1 with change_amount=6 held until change_ack, then credit=0.
REQ-040 Coin code 00 then cancel -> change_amount=1, no coffee_out; a coin sent with cancel -> coin_reject pulse.
REQ-041 Code 11, credit overflow at 38+10 with MAX_CREDIT=40, and a coin during CHANGE -> a coin_reject pulse each time, credit unchanged.
REQ-042 Reset asserted during CHANGE (change_amount=6) -> all outputs 0 at once, IDLE, no change issued after release.
REQ-043 Random coins, cancels, and acks, with a scoreboard -> dispensed units plus change units equal credited units.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared types and constants for the coffee vending controller.
package vending_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_COLLECT  = 2'd1,
        S_DISPENSE = 2'd2,
        S_CHANGE   = 2'd3
    } state_t;

    localparam logic [1:0] COIN_50  = 2'b00;
    localparam logic [1:0] COIN_100 = 2'b01;
    localparam logic [1:0] COIN_500 = 2'b10;
    localparam logic [1:0] COIN_BAD = 2'b11;

    // Coin values in 50-won units.
    localparam int UNIT_50  = 1;
    localparam int UNIT_100 = 2;
    localparam int UNIT_500 = 10;

endpackage

// File: rtl/vending_coin_decode.sv
// Combinational coin decoder: coin code to unit value plus a validity flag.
module vending_coin_decode
    import vending_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [1:0]   coin_code_i,
    output logic [W-1:0] value_o,
    output logic         is_valid_o
);

    always_comb begin
        value_o    = '0;
        is_valid_o = 1'b1;
        case (coin_code_i)
            COIN_50:  value_o = W'(UNIT_50);
            COIN_100: value_o = W'(UNIT_100);
            COIN_500: value_o = W'(UNIT_500);
            default:  is_valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/vending_ctrl.sv
// Vending controller: accumulates coin credit, dispenses one product per
// visit to DISPENSE and hands any remainder or refund to the change dispenser.
//
// state      | meaning
// S_IDLE     | no credit held
// S_COLLECT  | 0 < credit < PRICE, waiting for more coins or cancel
// S_DISPENSE | coffee_out pulse cycle, remainder computed on exit
// S_CHANGE   | change_amount offered, waiting for change_ack
module vending_ctrl
    import vending_pkg::*;
#(
    parameter int PRICE      = 4,
    parameter int MAX_CREDIT = 40,
    parameter int CREDIT_W   = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_valid,
    input  logic [1:0]          coin_code,
    input  logic                cancel,
    input  logic                change_ack,
    output logic                coffee_out,
    output logic                coin_reject,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amount,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    localparam logic [CREDIT_W:0]   PRICE_X = (CREDIT_W+1)'(PRICE);
    localparam logic [CREDIT_W:0]   MAX_X   = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

    state_t              state_q;
    logic [CREDIT_W-1:0] credit_q;
    logic [CREDIT_W-1:0] change_amt_q;
    logic                coffee_q;
    logic                reject_q;
    logic                change_valid_q;
    logic                busy_q;

    logic [CREDIT_W-1:0] coin_value;
    logic                coin_ok;
    logic [CREDIT_W:0]   credit_sum_d;
    logic [CREDIT_W-1:0] remainder_d;
    logic                accept_d;

    vending_coin_decode #(.W(CREDIT_W)) u_decode (
        .coin_code_i (coin_code),
        .value_o     (coin_value),
        .is_valid_o  (coin_ok)
    );

    // One extra bit keeps the overflow compare free of wrap-around.
    assign credit_sum_d = {1'b0, credit_q} + {1'b0, coin_value};
    assign remainder_d  = credit_q - PRICE_C;
    assign accept_d     = coin_valid && coin_ok && !cancel && (credit_sum_d <= MAX_X);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            credit_q       <= '0;
            change_amt_q   <= '0;
            coffee_q       <= 1'b0;
            reject_q       <= 1'b0;
            change_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            coffee_q <= 1'b0;
            reject_q <= 1'b0;
            case (state_q)
                S_IDLE, S_COLLECT: begin
                    if (cancel) begin
                        reject_q <= coin_valid;
                        if (state_q == S_COLLECT) begin
                            state_q        <= S_CHANGE;
                            change_valid_q <= 1'b1;
                            change_amt_q   <= credit_q;
                            busy_q         <= 1'b1;
                        end
                    end else if (accept_d) begin
                        credit_q <= credit_sum_d[CREDIT_W-1:0];
                        if (credit_sum_d >= PRICE_X) begin
                            state_q  <= S_DISPENSE;
                            coffee_q <= 1'b1;
                            busy_q   <= 1'b1;
                        end else begin
                            state_q <= S_COLLECT;
                        end
                    end else begin
                        reject_q <= coin_valid;
                    end
                end
                S_DISPENSE: begin
                    reject_q <= coin_valid;
                    credit_q <= remainder_d;
                    if (remainder_d != '0) begin
                        state_q        <= S_CHANGE;
                        change_valid_q <= 1'b1;
                        change_amt_q   <= remainder_d;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                S_CHANGE: begin
                    reject_q <= coin_valid;
                    if (change_ack) begin
                        state_q        <= S_IDLE;
                        change_valid_q <= 1'b0;
                        change_amt_q   <= '0;
                        credit_q       <= '0;
                        busy_q         <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign coffee_out    = coffee_q;
    assign coin_reject   = reject_q;
    assign change_valid  = change_valid_q;
    assign change_amount = change_amt_q;
    assign credit        = credit_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_vending_ctrl.sv
// Bench for vending_ctrl: directed scenarios plus random traffic against a
// credit-ledger reference model.
module tb_vending_ctrl;

    localparam int PRICE = 4;
    localparam int MAXC  = 40;
    localparam int W     = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         coin_valid, cancel, change_ack;
    logic [1:0]   coin_code;
    logic         coffee_out, coin_reject, change_valid, busy;
    logic [W-1:0] change_amount, credit;

    logic         b_coin_valid, b_cancel, b_change_ack;
    logic [1:0]   b_coin_code;
    logic         b_coffee_out, b_coin_reject, b_change_valid, b_busy;
    logic [W-1:0] b_change_amount, b_credit;

    always #5 clk = ~clk;

    vending_ctrl #(.PRICE(PRICE), .MAX_CREDIT(MAXC), .CREDIT_W(W)) dut (
        .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_code(coin_code),
        .cancel(cancel), .change_ack(change_ack), .coffee_out(coffee_out),
        .coin_reject(coin_reject), .change_valid(change_valid),
        .change_amount(change_amount), .credit(credit), .busy(busy)
    );

    // Price equal to the credit ceiling so credit can approach MAX_CREDIT.
    vending_ctrl #(.PRICE(40), .MAX_CREDIT(40), .CREDIT_W(W)) dut_big (
        .clk(clk), .reset(reset), .coin_valid(b_coin_valid), .coin_code(b_coin_code),
        .cancel(b_cancel), .change_ack(b_change_ack), .coffee_out(b_coffee_out),
        .coin_reject(b_coin_reject), .change_valid(b_change_valid),
        .change_amount(b_change_amount), .credit(b_credit), .busy(b_busy)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: credit held, and whether a product is owed or change is offered.
    int m_cr;
    bit m_disp, m_chg;
    int credited, obs_disp, obs_chg;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int coin_units(input logic [1:0] cd);
        case (cd)
            2'b00:   return 1;
            2'b01:   return 2;
            2'b10:   return 10;
            default: return -1;
        endcase
    endfunction

    task automatic step(input bit cv, input logic [1:0] cd, input bit can, input bit ack);
        bit rej, cof;
        int v;
        coin_valid = cv; coin_code = cd; cancel = can; change_ack = ack;
        if (change_valid && ack) obs_chg += int'(change_amount);
        @(posedge clk); #1;
        rej = 0; cof = 0;
        if (m_disp) begin
            rej = cv;
            m_cr -= PRICE;
            m_disp = 0;
            m_chg = (m_cr > 0);
        end else if (m_chg) begin
            rej = cv;
            if (ack) begin m_cr = 0; m_chg = 0; end
        end else if (can) begin
            rej = cv;
            if (m_cr > 0) m_chg = 1;
        end else if (cv) begin
            v = coin_units(cd);
            if (v > 0 && m_cr + v <= MAXC) begin
                m_cr += v;
                credited += v;
                if (m_cr >= PRICE) begin m_disp = 1; cof = 1; end
            end else begin
                rej = 1;
            end
        end
        if (coffee_out) obs_disp += PRICE;
        chk("coffee_out", coffee_out, cof);
        chk("coin_reject", coin_reject, rej);
        chk("change_valid", change_valid, m_chg);
        if (m_chg) chk("change_amount", change_amount, m_cr);
        chk("credit", credit, m_cr);
        chk("busy", busy, m_disp | m_chg);
    endtask

    task automatic bstep(input bit cv, input logic [1:0] cd);
        b_coin_valid = cv; b_coin_code = cd; b_cancel = 0; b_change_ack = 0;
        @(posedge clk); #1;
        b_coin_valid = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_coffee"}, coffee_out, 0);
        chk({tag, "_reject"}, coin_reject, 0);
        chk({tag, "_chg_valid"}, change_valid, 0);
        chk({tag, "_chg_amt"}, change_amount, 0);
        chk({tag, "_credit"}, credit, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        reset = 1;
        coin_valid = 0; coin_code = 0; cancel = 0; change_ack = 0;
        b_coin_valid = 0; b_coin_code = 0; b_cancel = 0; b_change_ack = 0;
        m_cr = 0; m_disp = 0; m_chg = 0;
        credited = 0; obs_disp = 0; obs_chg = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("rst");
        chk("rst_big_credit", b_credit, 0);
        reset = 0;

        // Two 100-won coins: exact price, no change.
        step(1, 2'b01, 0, 0);
        step(1, 2'b01, 0, 0);
        step(0, 2'b00, 0, 0);
        step(0, 2'b00, 0, 0);

        // 500-won coin: dispense then change of 6 held until ack.
        step(1, 2'b10, 0, 0);
        repeat (3) step(0, 2'b00, 0, 0);
        step(0, 2'b00, 0, 1);
        step(0, 2'b00, 0, 0);

        // 50 won then cancel; then a coin together with cancel.
        step(1, 2'b00, 0, 0);
        step(0, 2'b00, 1, 0);
        step(0, 2'b00, 0, 1);
        step(1, 2'b00, 0, 0);
        step(1, 2'b01, 1, 0);
        step(0, 2'b00, 0, 1);

        // Invalid code, coin during CHANGE, cancel/ack ignored while idle.
        step(1, 2'b11, 0, 0);
        step(0, 2'b00, 0, 0);
        step(1, 2'b10, 0, 0);
        step(0, 2'b00, 0, 0);
        step(1, 2'b00, 0, 0);
        step(0, 2'b00, 0, 1);
        step(0, 2'b00, 1, 0);
        step(0, 2'b00, 0, 1);

        // Overflow at 38 + 10 with MAX_CREDIT = 40.
        for (int i = 0; i < 3; i++) bstep(1, 2'b10);
        for (int i = 0; i < 4; i++) bstep(1, 2'b01);
        chk("big_credit38", b_credit, 38);
        bstep(1, 2'b10);
        chk("big_ovf_reject", b_coin_reject, 1);
        chk("big_ovf_credit", b_credit, 38);
        bstep(0, 2'b00);
        chk("big_reject_pulse", b_coin_reject, 0);
        bstep(1, 2'b01);
        chk("big_coffee", b_coffee_out, 1);
        chk("big_credit40", b_credit, 40);
        bstep(0, 2'b00);
        chk("big_after_credit", b_credit, 0);
        chk("big_after_chg", b_change_valid, 0);
        chk("big_after_busy", b_busy, 0);

        // Reset while change of 6 is offered.
        step(1, 2'b10, 0, 0);
        step(0, 2'b00, 0, 0);
        reset = 1;
        #1;
        chk_all_zero("async_rst");
        m_cr = 0; m_disp = 0; m_chg = 0;
        @(posedge clk); #1;
        reset = 0;
        repeat (3) step(0, 2'b00, 0, 0);
        step(0, 2'b00, 0, 1);

        // Random traffic with ledger check.
        credited = 0; obs_disp = 0; obs_chg = 0;
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0);
        end
        repeat (4) step(0, 2'b00, 1, 1);
        chk("drain_credit", credit, 0);
        chk("ledger", obs_disp + obs_chg, credited);
        chk("model_ledger", obs_disp + obs_chg + m_cr, credited);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
